// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port main-memory arbiter: FSM encoding and default timeout.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_valid,
    output logic o_winner
);

    assign o_valid  = i_req0 | i_req1;
    assign o_winner = (i_req0 & i_req1) ? ~i_last : i_req1;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between two requesters,
// with a single outstanding transaction and a WAIT-state timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_ready,
    output logic              r0_error,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_ready,
    output logic              r1_error,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              grant_id
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    arb_state_t       r_state;
    logic             r_last;
    logic             r_wr;
    logic [CNT_W-1:0] r_cnt;

    logic w_req0;
    logic w_req1;
    logic w_any;
    logic w_win;
    logic w_win_wr;

    assign w_req0   = r0_read | r0_write;
    assign w_req1   = r1_read | r1_write;
    // Write takes precedence when a requester raises both strobes.
    assign w_win_wr = w_win ? r1_write : r0_write;

    rr_pick2 u_pick (
        .i_req0   (w_req0),
        .i_req1   (w_req1),
        .i_last   (r_last),
        .o_valid  (w_any),
        .o_winner (w_win)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_wr      <= 1'b0;
            r_cnt     <= '0;
            r0_rdata  <= '0;
            r0_ready  <= 1'b0;
            r0_error  <= 1'b0;
            r1_rdata  <= '0;
            r1_ready  <= 1'b0;
            r1_error  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        grant_id  <= w_win;
                        r_wr      <= w_win_wr;
                        mem_addr  <= w_win ? r1_addr : r0_addr;
                        mem_wdata <= w_win ? r1_wdata : r0_wdata;
                        mem_read  <= ~w_win_wr;
                        mem_write <= w_win_wr;
                        busy      <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        if (grant_id) begin
                            r1_ready <= 1'b1;
                            r1_rdata <= r_wr ? '0 : mem_rdata;
                        end else begin
                            r0_ready <= 1'b1;
                            r0_rdata <= r_wr ? '0 : mem_rdata;
                        end
                        r_state <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Timed out: complete with error and zero data.
                        if (grant_id) begin
                            r1_ready <= 1'b1;
                            r1_error <= 1'b1;
                        end else begin
                            r0_ready <= 1'b1;
                            r0_error <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r0_ready <= 1'b0;
                    r0_error <= 1'b0;
                    r0_rdata <= '0;
                    r1_ready <= 1'b0;
                    r1_error <= 1'b0;
                    r1_rdata <= '0;
                    r_last   <= grant_id;
                    busy     <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
